// File: rtl/regfile_arbiter_pkg.sv
// Shared widths, types and FSM encoding for the register-file write-port arbiter.
package regfile_arb_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int NUM_REGS   = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0]     data_t;

    typedef enum logic [1:0] {
        IDLE,
        DBG_RESP,
        CLEAR
    } state_e;

endpackage

// File: rtl/regfile_arbiter_if.sv
// CPU writeback, debug port, clear control and register-file port bundle.
interface regfile_arbiter_if
    import regfile_arb_pkg::*;
();

    logic      cpu_we;
    reg_addr_t cpu_waddr;
    data_t     cpu_wdata;
    logic      cpu_stall;

    logic      dbg_valid;
    logic      dbg_ready;
    logic      dbg_write;
    reg_addr_t dbg_addr;
    data_t     dbg_wdata;
    logic      dbg_rvalid;
    data_t     dbg_rdata;

    logic      clear_req;
    logic      clear_busy;

    logic      rf_we;
    reg_addr_t rf_waddr;
    data_t     rf_wdata;
    reg_addr_t rf_raddr;
    data_t     rf_rdata;

    modport master (
        output cpu_we, cpu_waddr, cpu_wdata,
        output dbg_valid, dbg_write, dbg_addr, dbg_wdata,
        output clear_req, rf_rdata,
        input  cpu_stall, dbg_ready, dbg_rvalid, dbg_rdata,
        input  clear_busy, rf_we, rf_waddr, rf_wdata, rf_raddr
    );

    modport slave (
        input  cpu_we, cpu_waddr, cpu_wdata,
        input  dbg_valid, dbg_write, dbg_addr, dbg_wdata,
        input  clear_req, rf_rdata,
        output cpu_stall, dbg_ready, dbg_rvalid, dbg_rdata,
        output clear_busy, rf_we, rf_waddr, rf_wdata, rf_raddr
    );

endinterface

// File: rtl/regfile_arbiter_starve_counter.sv
// Counts consecutive refused debug-write cycles; flags a forced grant at the limit.
module starve_counter #(
    parameter int STARVE_LIMIT = 8
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic inc_i,
    input  logic clr_i,
    output logic force_o
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != CNT_W'(STARVE_LIMIT))) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign force_o = (cnt_q == CNT_W'(STARVE_LIMIT));

endmodule

// File: rtl/regfile_arbiter.sv
// Arbitrates the register-file write port between CPU writeback, a debug port
// and a 32-cycle clear sequence, with starvation protection for debug writes.
module regfile_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    regfile_arbiter_if.slave   bus
);

    state_e    state_q, state_d;
    reg_addr_t clr_cnt_q, clr_cnt_d;
    logic      rvalid_q, rvalid_d;
    data_t     rdata_q, rdata_d;

    logic in_idle, dbg_wr_pend, dbg_rd_pend;
    logic starve_force, forced, wr_accept, rd_accept;

    assign in_idle     = (state_q == IDLE);
    assign dbg_wr_pend = bus.dbg_valid &  bus.dbg_write;
    assign dbg_rd_pend = bus.dbg_valid & ~bus.dbg_write;
    assign forced      = starve_force & dbg_wr_pend & in_idle;
    assign wr_accept   = in_idle & dbg_wr_pend & (~bus.cpu_we | forced);
    assign rd_accept   = in_idle & dbg_rd_pend;

    starve_counter #(.STARVE_LIMIT(STARVE_LIMIT)) u_starve (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .inc_i   (in_idle & dbg_wr_pend & ~wr_accept),
        .clr_i   (~dbg_wr_pend | wr_accept),
        .force_o (starve_force)
    );

    assign bus.rf_raddr   = bus.dbg_addr;
    assign bus.dbg_rvalid = rvalid_q;
    assign bus.dbg_rdata  = rdata_q;

    always_comb begin
        // NOTE: every output and next-state gets a default first so no path infers a latch.
        state_d        = state_q;
        clr_cnt_d      = '0;
        rvalid_d       = rd_accept;
        rdata_d        = rd_accept ? bus.rf_rdata : rdata_q;
        bus.rf_we      = 1'b0;
        bus.rf_waddr   = bus.cpu_waddr;
        bus.rf_wdata   = bus.cpu_wdata;
        bus.cpu_stall  = 1'b0;
        bus.dbg_ready  = 1'b0;
        bus.clear_busy = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (wr_accept) begin
                    bus.rf_we     = 1'b1;
                    bus.rf_waddr  = bus.dbg_addr;
                    bus.rf_wdata  = bus.dbg_wdata;
                    bus.dbg_ready = 1'b1;
                    bus.cpu_stall = forced;
                end else begin
                    bus.rf_we     = bus.cpu_we;
                    bus.dbg_ready = rd_accept;
                end
                if (bus.clear_req) begin
                    state_d = CLEAR;
                end else if (rd_accept) begin
                    state_d = DBG_RESP;
                end
            end
            DBG_RESP: begin
                bus.rf_we = bus.cpu_we;
                state_d   = bus.clear_req ? CLEAR : IDLE;
            end
            CLEAR: begin
                bus.rf_we      = 1'b1;
                bus.rf_waddr   = clr_cnt_q;
                bus.rf_wdata   = '0;
                bus.cpu_stall  = 1'b1;
                bus.clear_busy = 1'b1;
                clr_cnt_d      = clr_cnt_q + reg_addr_t'(1);
                if (clr_cnt_q == reg_addr_t'(NUM_REGS - 1)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // NOTE: combinational outputs are gated by reset so nothing is written while rst_ni is low.
        if (!rst_ni) begin
            bus.rf_we      = 1'b0;
            bus.cpu_stall  = 1'b0;
            bus.dbg_ready  = 1'b0;
            bus.clear_busy = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            clr_cnt_q <= '0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
        end
    end

endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed self-checking bench for regfile_arbiter with hand-computed expectations.
module tb_regfile_arbiter;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_pass   = 0;

    regfile_arbiter_if bus ();

    regfile_arbiter #(.STARVE_LIMIT(8)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic check5(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.cpu_we    = 1'b0;
        bus.cpu_waddr = '0;
        bus.cpu_wdata = '0;
        bus.dbg_valid = 1'b0;
        bus.dbg_write = 1'b0;
        bus.dbg_addr  = '0;
        bus.dbg_wdata = '0;
        bus.clear_req = 1'b0;
    endtask

    initial begin
        rst_n = 1'b1;
        idle_inputs();
        bus.rf_rdata = '0;
        #1 rst_n = 1'b0;

        // Reset holds outputs quiet even with live requests.
        bus.cpu_we    = 1'b1;
        bus.cpu_waddr = 5'd5;
        bus.cpu_wdata = 32'h1234;
        bus.dbg_valid = 1'b1;
        bus.dbg_write = 1'b1;
        #10;
        check1 ("rst_rf_we",      bus.rf_we,      1'b0);
        check1 ("rst_cpu_stall",  bus.cpu_stall,  1'b0);
        check1 ("rst_dbg_ready",  bus.dbg_ready,  1'b0);
        check1 ("rst_dbg_rvalid", bus.dbg_rvalid, 1'b0);
        check32("rst_dbg_rdata",  bus.dbg_rdata,  32'h0);
        check1 ("rst_clear_busy", bus.clear_busy, 1'b0);
        idle_inputs();
        @(negedge clk) rst_n = 1'b1;

        tick(); mid();
        check1("idle_rf_we",     bus.rf_we,     1'b0);
        check1("idle_cpu_stall", bus.cpu_stall, 1'b0);
        check1("idle_dbg_ready", bus.dbg_ready, 1'b0);

        // CPU writeback passes through in the same cycle.
        tick();
        bus.cpu_we = 1'b1; bus.cpu_waddr = 5'd5; bus.cpu_wdata = 32'h1234;
        mid();
        check1 ("cpu_rf_we",    bus.rf_we,     1'b1);
        check5 ("cpu_rf_waddr", bus.rf_waddr,  5'd5);
        check32("cpu_rf_wdata", bus.rf_wdata,  32'h1234);
        check1 ("cpu_stall",    bus.cpu_stall, 1'b0);

        tick();
        bus.cpu_waddr = 5'd0; bus.cpu_wdata = 32'hFFFF;
        mid();
        check5 ("cpu_r0_waddr", bus.rf_waddr, 5'd0);
        check32("cpu_r0_wdata", bus.rf_wdata, 32'hFFFF);

        // Debug write with the CPU idle is accepted immediately.
        tick();
        idle_inputs();
        bus.dbg_valid = 1'b1; bus.dbg_write = 1'b1; bus.dbg_addr = 5'd9; bus.dbg_wdata = 32'h55;
        mid();
        check1 ("dbgw_ready",    bus.dbg_ready, 1'b1);
        check1 ("dbgw_rf_we",    bus.rf_we,     1'b1);
        check5 ("dbgw_rf_waddr", bus.rf_waddr,  5'd9);
        check32("dbgw_rf_wdata", bus.rf_wdata,  32'h55);
        check1 ("dbgw_stall",    bus.cpu_stall, 1'b0);

        // Debug read alongside a CPU write.
        tick();
        idle_inputs();
        bus.cpu_we = 1'b1; bus.cpu_waddr = 5'd4; bus.cpu_wdata = 32'h44;
        bus.dbg_valid = 1'b1; bus.dbg_write = 1'b0; bus.dbg_addr = 5'd7;
        bus.rf_rdata = 32'hDEADBEEF;
        mid();
        check1("dbgr_ready",    bus.dbg_ready, 1'b1);
        check5("dbgr_raddr",    bus.rf_raddr,  5'd7);
        check1("dbgr_cpu_we",   bus.rf_we,     1'b1);
        check5("dbgr_cpu_addr", bus.rf_waddr,  5'd4);
        tick();
        bus.dbg_valid = 1'b0; bus.rf_rdata = 32'h0;
        mid();
        check1 ("dbgr_rvalid",     bus.dbg_rvalid, 1'b1);
        check32("dbgr_rdata",      bus.dbg_rdata,  32'hDEADBEEF);
        check1 ("dbgr_resp_ready", bus.dbg_ready,  1'b0);
        check1 ("dbgr_resp_cpu",   bus.rf_we,      1'b1);
        tick();
        bus.cpu_we = 1'b0;
        mid();
        check1("dbgr_rvalid_end", bus.dbg_rvalid, 1'b0);

        // Reset during DBG_RESP kills the response.
        tick();
        bus.dbg_valid = 1'b1; bus.dbg_write = 1'b0; bus.dbg_addr = 5'd2; bus.rf_rdata = 32'hCAFE0001;
        mid();
        check1("rresp_ready", bus.dbg_ready, 1'b1);
        tick();
        bus.dbg_valid = 1'b0;
        mid();
        check1("rresp_rvalid", bus.dbg_rvalid, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        check1 ("rresp_rst_rvalid", bus.dbg_rvalid, 1'b0);
        check32("rresp_rst_rdata",  bus.dbg_rdata,  32'h0);
        @(negedge clk) rst_n = 1'b1;
        tick(); mid();
        check1("rresp_after_rvalid", bus.dbg_rvalid, 1'b0);

        // Starvation: refused for 8 cycles, forced grant in cycle 9.
        tick();
        idle_inputs();
        bus.cpu_we = 1'b1; bus.cpu_waddr = 5'd6; bus.cpu_wdata = 32'h66;
        bus.dbg_valid = 1'b1; bus.dbg_write = 1'b1; bus.dbg_addr = 5'd3; bus.dbg_wdata = 32'hAA;
        for (int i = 1; i <= 8; i++) begin
            mid();
            check1("starve_ready", bus.dbg_ready, 1'b0);
            check1("starve_stall", bus.cpu_stall, 1'b0);
            check5("starve_waddr", bus.rf_waddr,  5'd6);
            tick();
        end
        mid();
        check1 ("force_stall", bus.cpu_stall, 1'b1);
        check1 ("force_ready", bus.dbg_ready, 1'b1);
        check1 ("force_rf_we", bus.rf_we,     1'b1);
        check5 ("force_waddr", bus.rf_waddr,  5'd3);
        check32("force_wdata", bus.rf_wdata,  32'hAA);
        tick();
        bus.dbg_valid = 1'b0;
        mid();
        check1("post_force_stall", bus.cpu_stall, 1'b0);
        check5("post_force_waddr", bus.rf_waddr,  5'd6);

        // Clear sequence; re-requests mid-clear are ignored.
        tick();
        idle_inputs();
        bus.cpu_we = 1'b1; bus.cpu_waddr = 5'd31; bus.cpu_wdata = 32'hFF;
        bus.clear_req = 1'b1;
        mid();
        check1("clr_req_busy",  bus.clear_busy, 1'b0);
        check1("clr_req_stall", bus.cpu_stall,  1'b0);
        for (int i = 0; i < 32; i++) begin
            tick();
            bus.clear_req = (i == 5 || i == 6);
            bus.dbg_valid = (i == 5 || i == 6);
            bus.dbg_write = 1'b1;
            mid();
            check1 ("clr_busy",  bus.clear_busy, 1'b1);
            check1 ("clr_stall", bus.cpu_stall,  1'b1);
            check1 ("clr_rf_we", bus.rf_we,      1'b1);
            check5 ("clr_waddr", bus.rf_waddr,   5'(i));
            check32("clr_wdata", bus.rf_wdata,   32'h0);
            check1 ("clr_ready", bus.dbg_ready,  1'b0);
        end
        tick();
        bus.clear_req = 1'b0; bus.dbg_valid = 1'b0;
        mid();
        check1 ("clr_done_busy",  bus.clear_busy, 1'b0);
        check1 ("clr_done_stall", bus.cpu_stall,  1'b0);
        check5 ("clr_done_waddr", bus.rf_waddr,   5'd31);
        check32("clr_done_wdata", bus.rf_wdata,   32'hFF);

        // Debug write and clear together: write first, then 32 clear cycles.
        tick();
        idle_inputs();
        bus.dbg_valid = 1'b1; bus.dbg_write = 1'b1; bus.dbg_addr = 5'd10; bus.dbg_wdata = 32'hBB;
        bus.clear_req = 1'b1;
        mid();
        check1 ("both_ready", bus.dbg_ready,  1'b1);
        check5 ("both_waddr", bus.rf_waddr,   5'd10);
        check32("both_wdata", bus.rf_wdata,   32'hBB);
        check1 ("both_busy",  bus.clear_busy, 1'b0);
        for (int i = 0; i < 32; i++) begin
            tick();
            idle_inputs();
            mid();
            check1("both_clr_busy",  bus.clear_busy, 1'b1);
            check5("both_clr_waddr", bus.rf_waddr,   5'(i));
        end
        tick(); mid();
        check1("both_done_busy", bus.clear_busy, 1'b0);
        check1("both_done_we",   bus.rf_we,      1'b0);

        // Reset at clear counter 10 aborts the sequence immediately.
        tick();
        bus.clear_req = 1'b1;
        mid();
        for (int i = 0; i <= 10; i++) begin
            tick();
            bus.clear_req = 1'b0;
            mid();
            check5("abort_waddr", bus.rf_waddr, 5'(i));
        end
        #1 rst_n = 1'b0;
        #1;
        check1("abort_rf_we", bus.rf_we,      1'b0);
        check1("abort_busy",  bus.clear_busy, 1'b0);
        check1("abort_stall", bus.cpu_stall,  1'b0);
        @(negedge clk) rst_n = 1'b1;
        tick(); mid();
        check1("abort_rel_busy",  bus.clear_busy, 1'b0);
        check1("abort_rel_we",    bus.rf_we,      1'b0);
        check1("abort_rel_stall", bus.cpu_stall,  1'b0);
        tick(); mid();
        check1("abort_rel_we2",   bus.rf_we,      1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/regfile_arbiter.md
REGFILE_ARBITER -- requirements
Module: regfile_arbiter

Interface
REQ-001 The block SHALL have one parameter: STARVE_LIMIT, default 8, the number of consecutive cycles a pending debug write may be blocked by CPU writeback before the CPU is stalled.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-003 clock  in  1  rising-edge system clock.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 cpu_we  in  1  CPU writeback request.
REQ-006 cpu_waddr  in  5  CPU writeback register index.
REQ-007 cpu_wdata  in  32  CPU writeback data.
REQ-008 cpu_stall  out  1  CPU must hold its writeback and freeze PC.
REQ-009 dbg_valid  in  1  debug request valid.
REQ-010 dbg_ready  out  1  debug request accepted this cycle.
REQ-011 dbg_write  in  1  1 = write request, 0 = read request.
REQ-012 dbg_addr  in  5  debug register index.
REQ-013 dbg_wdata  in  32  debug write data.
REQ-014 dbg_rvalid  out  1  read data valid pulse.
REQ-015 dbg_rdata  out  32  read data.
REQ-016 clear_req  in  1  request to zero all 32 registers.
REQ-017 clear_busy  out  1  clear sequence in progress.
REQ-018 rf_we, rf_waddr[4:0], rf_wdata[31:0]  out  register-file write port.
REQ-019 rf_raddr  out  5  register-file debug read address.
REQ-020 rf_rdata  in  32  register-file debug read data, combinational from rf_raddr.

Function
REQ-021 The state machine SHALL have three states: IDLE, DBG_RESP and CLEAR.
REQ-022 In IDLE with cpu_we=1 and no forced grant, the block SHALL drive rf_we=1, rf_waddr=cpu_waddr and rf_wdata=cpu_wdata in the same cycle (zero latency).
REQ-023 In IDLE, a debug write (dbg_valid=1, dbg_write=1) SHALL be accepted only when cpu_we=0 or a forced grant is active.
  - On acceptance: dbg_ready=1, and the write port is driven from dbg_addr/dbg_wdata in that cycle.
REQ-024 Starvation counter:
  - Increments each cycle a debug write is pending and refused.
  - Clears on acceptance or when dbg_valid drops.
  - On reaching STARVE_LIMIT, the next cycle is a forced grant: cpu_stall=1 and the debug write is accepted.
REQ-025 In IDLE, a debug read (dbg_valid=1, dbg_write=0) SHALL always be accepted.
  - Acceptance cycle: dbg_ready=1, rf_raddr=dbg_addr, rf_rdata captured, transition to DBG_RESP.
  - Next cycle: dbg_rvalid=1 for one cycle with the captured data.
  - Debug read does not block the CPU.
REQ-026 In DBG_RESP, dbg_ready SHALL be 0 and the state SHALL return to IDLE after one cycle; CPU writes proceed normally in this state.
REQ-027 clear_req sampled high in IDLE or DBG_RESP SHALL enter CLEAR on the next edge. A DBG_RESP response in flight still completes its rvalid pulse.
REQ-028 In CLEAR, the block SHALL drive:
  - cpu_stall=1, clear_busy=1, dbg_ready=0.
  - rf_we=1, rf_wdata=0, rf_waddr=a 5-bit counter that runs 0..31.
  - After the address-31 cycle (32 cycles in total), the state returns to IDLE.
REQ-029 clear_req asserted during CLEAR SHALL be ignored; the counter SHALL not restart.
REQ-030 Simultaneous debug write and clear_req in IDLE: the debug write is accepted that cycle, then CLEAR begins.
REQ-031 Writes to index 0 SHALL be passed through unchanged; the register file enforces $0=0.
REQ-032 In IDLE with no request, the outputs SHALL be rf_we=0, cpu_stall=0 and dbg_ready=0.

Reset
REQ-033 While reset=0, the block SHALL hold state=IDLE and counters=0, and drive cpu_stall=0, dbg_ready=0, dbg_rvalid=0, dbg_rdata=0, clear_busy=0 and rf_we=0.
REQ-034 Reset asserted mid-CLEAR or mid-DBG_RESP SHALL abort the operation immediately, with no further writes issued.

Structure
REQ-035 Package regfile_arb_pkg SHALL hold the state encoding, REG_ADDR_W=5, DATA_W=32 and NUM_REGS=32.
REQ-036 The starvation counter SHALL be a sub-module, starve_counter, parameterised by STARVE_LIMIT.

Verification
REQ-037 CPU write only: cpu_we=1, waddr=5, wdata=0x1234 -> rf_we=1, rf_waddr=5, rf_wdata=0x1234 in the same cycle; cpu_stall=0.
REQ-038 Debug read: dbg_addr=7, rf_rdata=0xDEADBEEF -> dbg_ready=1 in cycle N; dbg_rvalid=1 with dbg_rdata=0xDEADBEEF in cycle N+1.
REQ-039 Starvation: cpu_we held at 1 with a debug write to addr 3 of 0xAA pending -> refused for 8 cycles; in cycle 9, cpu_stall=1, dbg_ready=1 and rf_waddr=3 with rf_wdata=0xAA.
REQ-040 Clear: clear_req pulse -> 32 cycles with rf_we=1, rf_wdata=0 and addresses 0..31, cpu_stall=1 throughout; IDLE follows on cycle 33.
REQ-041 Reset at clear counter=10 -> rf_we=0 and clear_busy=0 immediately; after release, the state is IDLE.
REQ-042 Debug write and clear_req together in IDLE with cpu_we=0 -> the debug write is issued first, then 32 clear cycles.
